// File: rtl/axis_trig_pkg.sv
// Shared definitions for the trigger-gated AXIS splitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axis_trig_pkg;

    // FSM encoding; values are visible on state_o so they are fixed here.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Saturation ceiling for the missed-trigger counter.
    localparam logic [15:0] MISSED_MAX = 16'hFFFF;

endpackage

// File: rtl/axis_lane_fifo.sv
// Per-lane FIFO, DEPTH entries of DATA_W bits, registered storage.
// Latency: 1 cycle from push to valid; no same-cycle bypass when empty.
// Backpressure: full is derived from registered pointers; push is ignored when full.
module axis_lane_fifo #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign valid     = ~w_empty;
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~w_empty;

    // Output is forced to zero while empty so idle lanes present clean data.
    assign dout = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update; reset discards any buffered entries.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/axis_trig_splitter_nch.sv
// Holds the input stream until a trigger edge, then splits one packet into NCH lane streams.
// Latency: trigger sampled at edge t -> RUN after edge t+SYNC_STAGES; accepted beat -> lane valid 1 cycle later.
// Backpressure: s_axis_tready only in RUN and while every lane FIFO has space; slowest lane paces input.
module axis_trig_splitter_nch
    import axis_trig_pkg::*;
#(
    parameter int LANE_W      = 16,
    parameter int NCH         = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [NCH*LANE_W-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [NCH*LANE_W-1:0] m_axis_tdata,
    output logic [NCH-1:0]        m_axis_tvalid,
    input  logic [NCH-1:0]        m_axis_tready,
    output logic [NCH-1:0]        m_axis_tlast,
    input  logic                  trigger_in,
    input  logic                  arm,
    input  logic                  continuous,
    output logic [1:0]            state_o,
    output logic [15:0]           missed_trig
);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic [15:0]            r_missed_trig;

    logic                   w_sync_out;
    logic                   w_trig_rise;
    logic                   w_accept;
    logic                   w_last_acc;
    logic [NCH-1:0]         w_full;
    logic [LANE_W:0]        w_lane_dout [NCH];

    assign w_sync_out  = r_sync[SYNC_STAGES-1];
    assign w_trig_rise = w_sync_out & ~r_sync_prev;

    // Ready depends only on state and registered FIFO status, never on tvalid.
    assign s_axis_tready = (r_state == ST_RUN) & ~(|w_full);
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_last_acc    = w_accept & s_axis_tlast;

    assign state_o     = r_state;
    assign missed_trig = r_missed_trig;

    // Synchronise the asynchronous trigger and keep the previous value for edge detection.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], trigger_in};
            r_sync_prev <= w_sync_out;
        end
    end

    // Control FSM: arm from IDLE, start on trigger edge, finish on accepted tlast.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (arm)         r_state <= ST_ARMED;
                ST_ARMED: if (w_trig_rise) r_state <= ST_RUN;
                ST_RUN:   if (w_last_acc)  r_state <= continuous ? ST_ARMED : ST_IDLE;
                default:                   r_state <= ST_IDLE;
            endcase
        end
    end

    // Count edges that arrive while a packet is in flight, including one coinciding with tlast.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_missed_trig <= '0;
        end else if ((r_state == ST_RUN) && w_trig_rise && (r_missed_trig != MISSED_MAX)) begin
            r_missed_trig <= r_missed_trig + 16'd1;
        end
    end

    // One FIFO per lane, all written in lockstep on an accepted beat, drained independently.
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        axis_lane_fifo #(
            .DATA_W (LANE_W + 1),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .aclk    (aclk),
            .aresetn (aresetn),
            .push    (w_accept),
            .din     ({s_axis_tlast, s_axis_tdata[k*LANE_W +: LANE_W]}),
            .full    (w_full[k]),
            .pop     (m_axis_tready[k]),
            .dout    (w_lane_dout[k]),
            .valid   (m_axis_tvalid[k])
        );

        assign m_axis_tdata[k*LANE_W +: LANE_W] = w_lane_dout[k][LANE_W-1:0];
        assign m_axis_tlast[k]                  = w_lane_dout[k][LANE_W];
    end

endmodule

// File: tb/tb_axis_trig_splitter_nch.sv
module tb_axis_trig_splitter_nch;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] m_tdata;
    logic [1:0]  m_tvalid;
    logic [1:0]  m_tready;
    logic [1:0]  m_tlast;
    logic        trigger_in;
    logic        arm;
    logic        continuous;
    logic [1:0]  state_o;
    logic [15:0] missed_trig;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] BP_BASE  = 32'hB000C000;
    localparam logic [31:0] BP_STEP  = 32'h00010001;

    axis_trig_splitter_nch #(
        .LANE_W      (16),
        .NCH         (2),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .trigger_in    (trigger_in),
        .arm           (arm),
        .continuous    (continuous),
        .state_o       (state_o),
        .missed_trig   (missed_trig)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Two-cycle high pulse followed by two low cycles so the synchroniser settles.
    task automatic trig_pulse();
        trigger_in = 1'b1;
        tick();
        tick();
        trigger_in = 1'b0;
        tick();
        tick();
    endtask

    // Stream n beats (base+i) with all lanes ready; each beat must appear one cycle after accept.
    task automatic run_pkt(input string tag, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            s_tdata  = base + 32'(i);
            s_tlast  = (i == n - 1);
            s_tvalid = 1'b1;
            tick();
            chk({tag, "_vld"},  {30'd0, m_tvalid}, 32'h3);
            chk({tag, "_dat"},  m_tdata, base + 32'(i));
            chk({tag, "_last"}, {30'd0, m_tlast}, (i == n - 1) ? 32'h3 : 32'h0);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        chk({tag, "_drained"}, {30'd0, m_tvalid}, 32'h0);
    endtask

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic        acc_now;
    int          n_acc;
    logic        seen_rdy;
    logic [31:0] exp_beat;

    initial begin
        aresetn    = 1'b0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready   = 2'b00;
        trigger_in = 1'b0;
        arm        = 1'b0;
        continuous = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk("rst_state",  {30'd0, state_o}, 32'h0);
        chk("rst_tready", {31'd0, s_tready}, 32'h0);
        chk("rst_tvalid", {30'd0, m_tvalid}, 32'h0);
        chk("rst_tdata",  m_tdata, 32'h0);
        chk("rst_tlast",  {30'd0, m_tlast}, 32'h0);
        chk("rst_missed", {16'd0, missed_trig}, 32'h0);
        aresetn = 1'b1;

        // Data offered but never armed: nothing accepted for 20 cycles.
        m_tready = 2'b11;
        s_tdata  = 32'hAAAA5555;
        s_tvalid = 1'b1;
        seen_rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            seen_rdy = seen_rdy | s_tready;
            tick();
        end
        chk("idle_tready_never", {31'd0, seen_rdy}, 32'h0);
        chk("idle_state",        {30'd0, state_o}, 32'h0);
        chk("idle_no_output",    {30'd0, m_tvalid}, 32'h0);

        // Trigger in IDLE is ignored and not counted.
        trig_pulse();
        chk("idle_trig_state",  {30'd0, state_o}, 32'h0);
        chk("idle_trig_missed", {16'd0, missed_trig}, 32'h0);

        // Arm, then trigger: RUN two edges after the trigger is first sampled.
        arm_pulse();
        chk("armed_state", {30'd0, state_o}, 32'h1);
        trigger_in = 1'b1;
        tick();
        tick();
        chk("sync_not_yet", {30'd0, state_o}, 32'h1);
        chk("sync_no_rdy",  {31'd0, s_tready}, 32'h0);
        tick();
        chk("run_state",  {30'd0, state_o}, 32'h2);
        chk("run_tready", {31'd0, s_tready}, 32'h1);
        chk("run_no_out", {30'd0, m_tvalid}, 32'h0);

        // One-shot 8-beat packet starting with 0x12345678 (lane0 0x5678, lane1 0x1234).
        run_pkt("oneshot", 8, 32'h12345678);
        chk("oneshot_end_state", {30'd0, state_o}, 32'h0);
        chk("oneshot_end_rdy",   {31'd0, s_tready}, 32'h0);
        trigger_in = 1'b0;
        repeat (3) tick();
        chk("oneshot_missed", {16'd0, missed_trig}, 32'h0);

        // Continuous mode: two packets, triggers about 50 cycles apart.
        continuous = 1'b1;
        arm_pulse();
        trig_pulse();
        chk("cont1_state", {30'd0, state_o}, 32'h2);
        run_pkt("cont1", 3, 32'h0A000100);
        chk("cont1_rearm", {30'd0, state_o}, 32'h1);
        repeat (40) tick();
        chk("cont_gap_state", {30'd0, state_o}, 32'h1);
        chk("cont_gap_out",   {30'd0, m_tvalid}, 32'h0);
        trig_pulse();
        chk("cont2_state", {30'd0, state_o}, 32'h2);
        run_pkt("cont2", 3, 32'h0B000200);
        chk("cont2_rearm", {30'd0, state_o}, 32'h1);

        // Missed triggers while in RUN.
        trig_pulse();
        chk("miss_run_state", {30'd0, state_o}, 32'h2);
        repeat (3) trig_pulse();
        chk("miss_count3", {16'd0, missed_trig}, 32'h3);
        chk("miss_state",  {30'd0, state_o}, 32'h2);

        // Saturation: preload near the ceiling, then three more edges.
        @(negedge aclk);
        force dut.r_missed_trig = 16'hFFFE;
        @(negedge aclk);
        release dut.r_missed_trig;
        tick();
        chk("miss_preload", {16'd0, missed_trig}, 32'h0000FFFE);
        repeat (3) trig_pulse();
        chk("miss_saturate", {16'd0, missed_trig}, 32'h0000FFFF);

        // Backpressure: lane1 stalled, 8-beat packet, then release lane1.
        continuous = 1'b0;
        m_tready   = 2'b01;
        s_tdata    = BP_BASE;
        s_tlast    = 1'b0;
        s_tvalid   = 1'b1;
        n_acc      = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc == 8) begin
                chk("bp_accepts",    32'(n_acc), 32'd4);
                chk("bp_tready_low", {31'd0, s_tready}, 32'h0);
                m_tready = 2'b11;
            end
            acc_now = s_tvalid & s_tready;
            if (m_tvalid[0] & m_tready[0]) q0.push_back({m_tlast[0], m_tdata[15:0]});
            if (m_tvalid[1] & m_tready[1]) q1.push_back({m_tlast[1], m_tdata[31:16]});
            tick();
            if (acc_now) begin
                n_acc++;
                if (n_acc == 8) begin
                    s_tvalid = 1'b0;
                    s_tlast  = 1'b0;
                end else begin
                    s_tdata = BP_BASE + 32'(n_acc) * BP_STEP;
                    s_tlast = (n_acc == 7);
                end
            end
        end
        chk("bp_total_acc", 32'(n_acc), 32'd8);
        chk("bp_q0_len", 32'(q0.size()), 32'd8);
        chk("bp_q1_len", 32'(q1.size()), 32'd8);
        for (int j = 0; j < 8; j++) begin
            exp_beat = BP_BASE + 32'(j) * BP_STEP;
            chk("bp_lane0_word", (j < q0.size()) ? {15'd0, q0[j]} : 32'hXXXXXXXX,
                {15'd0, (j == 7), exp_beat[15:0]});
            chk("bp_lane1_word", (j < q1.size()) ? {15'd0, q1[j]} : 32'hXXXXXXXX,
                {15'd0, (j == 7), exp_beat[31:16]});
        end
        chk("bp_end_state", {30'd0, state_o}, 32'h0);

        // Reset mid-packet discards buffered data and returns to IDLE.
        arm_pulse();
        trig_pulse();
        chk("mid_run_state", {30'd0, state_o}, 32'h2);
        m_tready = 2'b00;
        s_tdata  = 32'hDEAD0001;
        s_tvalid = 1'b1;
        tick();
        s_tdata  = 32'hDEAD0002;
        tick();
        s_tvalid = 1'b0;
        chk("mid_buffered", {30'd0, m_tvalid}, 32'h3);
        aresetn = 1'b0;
        tick();
        chk("mid_rst_tvalid", {30'd0, m_tvalid}, 32'h0);
        chk("mid_rst_state",  {30'd0, state_o}, 32'h0);
        chk("mid_rst_tready", {31'd0, s_tready}, 32'h0);
        chk("mid_rst_tdata",  m_tdata, 32'h0);
        chk("mid_rst_missed", {16'd0, missed_trig}, 32'h0);
        aresetn = 1'b1;
        tick();
        chk("post_rst_tvalid", {30'd0, m_tvalid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
